hash_result_scorer: RTL
=======================

// Module: hash_result_scorer
// PURPOSE
// - Consumer of the Threefish/Skein engine's finished hash: fires on the hash-register write pulse.
// - Reads the 1024-bit hash word by word and XORs each word with the target word.
// - Popcounts the result to get the Hamming distance, and keeps the best (lowest) distance and its nonce.
// - Offers each new best to the host/UART side on a valid/ready handshake.
// PARAMETERS
// - WORD_W    64  bits per hash/target word
// - NUM_WORDS 16  words per hash (1024 bits)
// - NONCE_W   64  width of candidate identifier captured per hash
// - SCORE_W   11  distance width = $clog2(WORD_W*NUM_WORDS+1); fixed by the two above
// PORTS
// - clk_i            in   1        single clock, all logic on posedge
// - rst_n_i          in   1        asynchronous, active-low reset
// - hash_valid_i     in   1        1-cycle pulse: hash register just written (engine output mode)
// - nonce_i          in   NONCE_W  candidate id; sampled on accepted hash_valid_i
// - hash_word_sel_o  out  4        word index into hash register and target ROM
// - hash_word_i      in   WORD_W   hash word at hash_word_sel_o (combinational, same cycle)
// - target_word_i    in   WORD_W   target word at hash_word_sel_o (combinational, same cycle)
// - clear_best_i     in   1        sync: reset best score, drop pending report, clear overrun
// - busy_o           out  1        scan in progress (state != IDLE)
// - overrun_o        out  1        sticky: hash_valid_i arrived while busy
// - hash_count_o     out  32       hashes scored, wraps at 2^32
// - result_valid_o   out  1        new-best report available
// - result_ready_i   in   1        host accepts report
// - result_score_o   out  SCORE_W  reported distance
// - result_nonce_o   out  NONCE_W  reported nonce
// BEHAVIOUR
// - Reset values:
//   - outputs: all 0.
//   - best_score: all ones (2047), so the first hash always counts as an improvement.
//   - FSM: IDLE.
// - FSM: IDLE -> SCAN (16 cyc) -> DRAIN (1) -> COMPARE (1) -> IDLE.
//   - IDLE: on hash_valid_i, capture nonce_i, clear acc, clear word counter, go to SCAN.
//   - SCAN: hash_word_sel_o = counter 0..15.
//     - pc_q <= popcount(hash_word_i ^ target_word_i).
//     - acc += pc_q from the second SCAN cycle on.
//     - Leave SCAN after counter reaches 15.
//   - DRAIN: acc += pc_q (adds word 15).
//   - COMPARE: hash_count_o++; if acc < best_score (strict, so ties keep the earlier nonce), load best_score/best_nonce and set new_best.
//   - hash_word_sel_o = 0 outside SCAN.
// - Latency: hash_valid_i sampled at edge T0 -> SCAN T1..T16, DRAIN T17, COMPARE T18; result_valid_o high from T19.
// - Report stage (separate output regs):
//   - If result_valid_o is low and new_best is set: load result_* from best_*, raise valid, clear new_best.
//   - Payload is stable while result_valid_o && !result_ready_i.
//   - A better hash found while a report is pending only sets new_best; it is presented the cycle after the handshake completes.
//   - Report holds the then-current best.
// - hash_valid_i outside IDLE: ignored, overrun_o <= 1 (sticky).
// - clear_best_i (any state):
//   - best_score <= all ones; new_best, result_valid_o, overrun_o <= 0.
//   - Does not abort a scan; the scan in flight completes and compares against the cleared best.
//   - In the same cycle as COMPARE: clear wins, no update that cycle; hash_count_o still increments.
// - Widths: popcount 7 bits, zero-extended into acc. acc max 1024 fits SCORE_W, so there is no overflow.
// - Async reset mid-scan: everything returns to its reset value immediately; no partial report.
// STRUCTURE
// - Shared package skein_pkg:
//   - WORD_W, NUM_WORDS, SCORE_W localparams.
//   - scorer state encoding (IDLE=0, SCAN=1, DRAIN=2, COMPARE=3).
// - Sub-module popcount64: combinational 64-bit population count (adder tree, 7-bit out).
//   - Reused by later distance blocks.
// - Everything else is flat in this module.
// TESTING
// - Identical hash: hash=target, nonce 0x5 -> result_score_o=0, result_nonce_o=0x5, valid at T19, hash_count_o=1.
// - Full mismatch: hash=~target -> score 1024 (11'h400).
//   - Follow with a hash differing in 3 bits of word 15 -> score 3, confirming the DRAIN add.
// - Backpressure: ready=0; hashes scored 500 then 200 -> payload held at 500.
//   - ready pulse -> next cycle valid with 200; a tie at 200 is never reported.
// - Overrun: second hash_valid_i at T5 of a scan -> ignored, overrun_o=1, hash_count_o +1 only.
//   - clear_best_i clears overrun_o.
// - clear_best_i asserted on the COMPARE cycle of a score-10 hash -> no report, best=2047.
//   - Next hash scoring 900 is reported.
// - Async reset asserted at T8 of a scan -> all outputs 0 the same cycle.
//   - Next hash after release completes normally.

Source files
------------

// File: rtl/skein_pkg.sv
// Shared Skein/Threefish constants and the result scorer's state encoding.
package skein_pkg;
  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 16;
  localparam int SCORE_W   = $clog2(WORD_W * NUM_WORDS + 1);
  localparam int SEL_W     = $clog2(NUM_WORDS);
  localparam int PC_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_COMPARE = 2'd3
  } scorer_state_e;
endpackage

// File: rtl/popcount64.sv
// Combinational 64-bit population count built as a balanced pairwise adder tree.
module popcount64 (
  input  logic [63:0] a,
  output logic [6:0]  cnt
);
  logic [31:0][1:0] s1;
  logic [15:0][2:0] s2;
  logic [7:0][3:0]  s3;
  logic [3:0][4:0]  s4;
  logic [1:0][5:0]  s5;

  for (genvar i = 0; i < 32; i++) begin : g_l1
    assign s1[i] = {1'b0, a[2*i]} + {1'b0, a[2*i+1]};
  end
  for (genvar i = 0; i < 16; i++) begin : g_l2
    assign s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
  end
  for (genvar i = 0; i < 8; i++) begin : g_l3
    assign s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
  end
  for (genvar i = 0; i < 4; i++) begin : g_l4
    assign s4[i] = {1'b0, s3[2*i]} + {1'b0, s3[2*i+1]};
  end
  for (genvar i = 0; i < 2; i++) begin : g_l5
    assign s5[i] = {1'b0, s4[2*i]} + {1'b0, s4[2*i+1]};
  end
  assign cnt = {1'b0, s5[0]} + {1'b0, s5[1]};
endmodule

// File: rtl/hash_result_scorer.sv
// Scores each finished hash by Hamming distance to the target, tracks the best
// (lowest) distance and its nonce, and offers every new best on valid/ready.
module hash_result_scorer
  import skein_pkg::*;
#(
  parameter int NONCE_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               hash_valid_i,
  input  logic [NONCE_W-1:0] nonce_i,
  output logic [SEL_W-1:0]   hash_word_sel_o,
  input  logic [WORD_W-1:0]  hash_word_i,
  input  logic [WORD_W-1:0]  target_word_i,
  input  logic               clear_best_i,
  output logic               busy_o,
  output logic               overrun_o,
  output logic [31:0]        hash_count_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [SCORE_W-1:0] result_score_o,
  output logic [NONCE_W-1:0] result_nonce_o
);
  localparam logic [SEL_W-1:0] LAST_WORD = SEL_W'(NUM_WORDS - 1);

  scorer_state_e      state;
  logic [SEL_W-1:0]   cnt;
  logic [PC_W-1:0]    pc_q, pc_w;
  logic [SCORE_W-1:0] acc, best_score;
  logic [NONCE_W-1:0] nonce_q, best_nonce;
  logic               new_best;

  popcount64 u_pc (.a(hash_word_i ^ target_word_i), .cnt(pc_w));

  assign hash_word_sel_o = (state == ST_SCAN) ? cnt : '0;
  assign busy_o          = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      pc_q           <= '0;
      acc            <= '0;
      best_score     <= '1;
      nonce_q        <= '0;
      best_nonce     <= '0;
      new_best       <= 1'b0;
      overrun_o      <= 1'b0;
      hash_count_o   <= '0;
      result_valid_o <= 1'b0;
      result_score_o <= '0;
      result_nonce_o <= '0;
    end else begin
      pc_q <= pc_w;

      // Report stage: a pending report blocks reloading so the payload stays put.
      if (result_valid_o && result_ready_i) begin
        result_valid_o <= 1'b0;
      end else if (!result_valid_o && new_best) begin
        result_valid_o <= 1'b1;
        result_score_o <= best_score;
        result_nonce_o <= best_nonce;
        new_best       <= 1'b0;
      end

      case (state)
        ST_IDLE: if (hash_valid_i) begin
          nonce_q <= nonce_i;
          acc     <= '0;
          cnt     <= '0;
          state   <= ST_SCAN;
        end
        ST_SCAN: begin
          // pc_q lags one word, so the first SCAN cycle has nothing to add yet.
          if (cnt != '0) acc <= acc + SCORE_W'(pc_q);
          cnt <= cnt + 1'b1;
          if (cnt == LAST_WORD) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          acc   <= acc + SCORE_W'(pc_q);
          state <= ST_COMPARE;
        end
        ST_COMPARE: begin
          hash_count_o <= hash_count_o + 32'd1;
          if (!clear_best_i && acc < best_score) begin
            best_score <= acc;
            best_nonce <= nonce_q;
            new_best   <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (hash_valid_i && state != ST_IDLE) overrun_o <= 1'b1;

      if (clear_best_i) begin
        best_score     <= '1;
        new_best       <= 1'b0;
        result_valid_o <= 1'b0;
        overrun_o      <= 1'b0;
      end
    end
  end
endmodule
